// File: rtl/psx_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : psx_mem_arbiter                                              |
// | Description : Shares the PSX-side DDR bridge port between NCLIENT          |
// |               requesters. One command slot is buffered per client, slots  |
// |               are granted round-robin, one command is in flight at a time, |
// |               and read data is routed back to the owning client.           |
// | Options     : PSX_ARB_FIXED_PRIO_EN - fixed priority, lowest index wins.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module psx_mem_arbiter #(
  parameter int NCLIENT = 3,
  parameter int PTR_W   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NCLIENT-1:0]       i_cmd,
  input  logic [NCLIENT-1:0]       i_write,
  input  logic [2*NCLIENT-1:0]     i_size,
  input  logic [15*NCLIENT-1:0]    i_adr,
  input  logic [3*NCLIENT-1:0]     i_subAdr,
  input  logic [16*NCLIENT-1:0]    i_mask,
  input  logic [256*NCLIENT-1:0]   i_data,
  output logic [NCLIENT-1:0]       o_busy,
  output logic [NCLIENT-1:0]       o_dataValid,
  output logic [255:0]             o_data,
  output logic                     o_memCmd,
  output logic                     o_memWrite,
  output logic [1:0]               o_memSize,
  output logic [14:0]              o_memAdr,
  output logic [2:0]               o_memSubAdr,
  output logic [15:0]              o_memMask,
  output logic [255:0]             o_memData,
  input  logic                     i_memBusy,
  input  logic                     i_memDataValid,
  input  logic [255:0]             i_memData,
  output logic [PTR_W-1:0]         o_owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_W = 2'd2,
    ST_WAIT_R = 2'd3
  } state_t;

  state_t                      state_q, state_d;

  // Per-client command slots
  logic [NCLIENT-1:0]          slot_valid_q, slot_valid_d;
  logic [NCLIENT-1:0]          slot_write_q, slot_write_d;
  logic [NCLIENT-1:0][1:0]     slot_size_q, slot_size_d;
  logic [NCLIENT-1:0][14:0]    slot_adr_q, slot_adr_d;
  logic [NCLIENT-1:0][2:0]     slot_sub_q, slot_sub_d;
  logic [NCLIENT-1:0][15:0]    slot_mask_q, slot_mask_d;
  logic [NCLIENT-1:0][255:0]   slot_data_q, slot_data_d;

  // Arbitration and bridge-side registers
  logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]            owner_q, owner_d;
  logic                        wait_first_q, wait_first_d;
  logic                        mem_cmd_q, mem_cmd_d;
  logic                        mem_write_q, mem_write_d;
  logic [1:0]                  mem_size_q, mem_size_d;
  logic [14:0]                 mem_adr_q, mem_adr_d;
  logic [2:0]                  mem_sub_q, mem_sub_d;
  logic [15:0]                 mem_mask_q, mem_mask_d;
  logic [255:0]                mem_data_q, mem_data_d;
  logic [255:0]                rdata_q, rdata_d;
  logic [NCLIENT-1:0]          dvalid_q, dvalid_d;

  logic                        slot_clr;
  logic                        sel_found;
  logic [PTR_W-1:0]            sel_idx;
  logic                        found_hi;
  logic [PTR_W-1:0]            idx_hi;
  logic [PTR_W-1:0]            idx_lo;

  // Winner selection over registered slots only, so a same-cycle capture waits a cycle
  always_comb begin
    sel_found = 1'b0;
    found_hi  = 1'b0;
    idx_hi    = '0;
    idx_lo    = '0;
    // Descending scan: the last hit written is the lowest qualifying index
    for (int k = NCLIENT-1; k >= 0; k--) begin
      if (slot_valid_q[k]) begin
        sel_found = 1'b1;
        idx_lo    = PTR_W'(k);
        if (PTR_W'(k) > rr_ptr_q) begin
          found_hi = 1'b1;
          idx_hi   = PTR_W'(k);
        end
      end
    end
`ifdef PSX_ARB_FIXED_PRIO_EN
    sel_idx = idx_lo;
`else
    // First valid slot after the pointer, wrapping to the lowest valid slot
    sel_idx = found_hi ? idx_hi : idx_lo;
`endif
  end

  // Slot capture on a client pulse into an empty slot; owner's slot frees on completion
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_write_d = slot_write_q;
    slot_size_d  = slot_size_q;
    slot_adr_d   = slot_adr_q;
    slot_sub_d   = slot_sub_q;
    slot_mask_d  = slot_mask_q;
    slot_data_d  = slot_data_q;
    for (int k = 0; k < NCLIENT; k++) begin
      if (i_cmd[k] && !slot_valid_q[k]) begin
        slot_valid_d[k] = 1'b1;
        slot_write_d[k] = i_write[k];
        slot_size_d[k]  = i_size[2*k +: 2];
        slot_adr_d[k]   = i_adr[15*k +: 15];
        slot_sub_d[k]   = i_subAdr[3*k +: 3];
        slot_mask_d[k]  = i_mask[16*k +: 16];
        slot_data_d[k]  = i_data[256*k +: 256];
      end
    end
    // The owner's slot is valid while in flight, so it never collides with a capture
    if (slot_clr) begin
      slot_valid_d[owner_q] = 1'b0;
    end
  end

  // Grant / issue / wait sequencing towards the bridge
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    wait_first_d = 1'b0;
    mem_cmd_d    = 1'b0;
    mem_write_d  = mem_write_q;
    mem_size_d   = mem_size_q;
    mem_adr_d    = mem_adr_q;
    mem_sub_d    = mem_sub_q;
    mem_mask_d   = mem_mask_q;
    mem_data_d   = mem_data_q;
    rdata_d      = rdata_q;
    dvalid_d     = '0;
    slot_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Hold off while the bridge is still busy (e.g. draining after a reset)
        if (!i_memBusy && sel_found) begin
          mem_cmd_d   = 1'b1;
          mem_write_d = slot_write_q[sel_idx];
          mem_size_d  = slot_size_q[sel_idx];
          mem_adr_d   = slot_adr_q[sel_idx];
          mem_sub_d   = slot_sub_q[sel_idx];
          mem_mask_d  = slot_mask_q[sel_idx];
          mem_data_d  = slot_data_q[sel_idx];
          owner_d     = sel_idx;
          rr_ptr_d    = sel_idx;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_first_d = 1'b1;
        state_d      = mem_write_q ? ST_WAIT_W : ST_WAIT_R;
      end
      ST_WAIT_W: begin
        // Bridge raises busy one cycle late, so its first busy sample is meaningless
        if (!wait_first_q && !i_memBusy) begin
          slot_clr = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_R: begin
        if (i_memDataValid) begin
          rdata_d           = i_memData;
          dvalid_d[owner_q] = 1'b1;
          slot_clr          = 1'b1;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and bridge-facing registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      slot_valid_q <= '0;
      rr_ptr_q     <= PTR_W'(NCLIENT-1);
      owner_q      <= '0;
      wait_first_q <= 1'b0;
      mem_cmd_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_size_q   <= '0;
      mem_adr_q    <= '0;
      mem_sub_q    <= '0;
      mem_mask_q   <= '0;
      mem_data_q   <= '0;
      rdata_q      <= '0;
      dvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      wait_first_q <= wait_first_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_write_q  <= mem_write_d;
      mem_size_q   <= mem_size_d;
      mem_adr_q    <= mem_adr_d;
      mem_sub_q    <= mem_sub_d;
      mem_mask_q   <= mem_mask_d;
      mem_data_q   <= mem_data_d;
      rdata_q      <= rdata_d;
      dvalid_q     <= dvalid_d;
    end
  end

  // Slot payload is qualified by slot_valid_q, so it needs no reset
  always_ff @(posedge i_clk) begin
    slot_write_q <= slot_write_d;
    slot_size_q  <= slot_size_d;
    slot_adr_q   <= slot_adr_d;
    slot_sub_q   <= slot_sub_d;
    slot_mask_q  <= slot_mask_d;
    slot_data_q  <= slot_data_d;
  end

  assign o_busy      = slot_valid_q;
  assign o_dataValid = dvalid_q;
  assign o_data      = rdata_q;
  assign o_memCmd    = mem_cmd_q;
  assign o_memWrite  = mem_write_q;
  assign o_memSize   = mem_size_q;
  assign o_memAdr    = mem_adr_q;
  assign o_memSubAdr = mem_sub_q;
  assign o_memMask   = mem_mask_q;
  assign o_memData   = mem_data_q;
  assign o_owner     = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_psx_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_psx_mem_arbiter                                           |
// | Description : Self-checking bench for psx_mem_arbiter with a bridge model  |
// |               and a transaction-level reference of slots and grants.       |
// | Options     : PSX_ARB_FIXED_PRIO_EN - reference uses fixed priority.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_psx_mem_arbiter;
  localparam int NC = 3;
  localparam int PW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     cmd_v, wr_v;
  logic [2*NC-1:0]   size_v;
  logic [15*NC-1:0]  adr_v;
  logic [3*NC-1:0]   sub_v;
  logic [16*NC-1:0]  mask_v;
  logic [256*NC-1:0] data_v;
  logic [NC-1:0]     o_busy, o_dataValid;
  logic [255:0]      o_data, o_memData, mem_rdata;
  logic              o_memCmd, o_memWrite, mem_busy, mem_dv;
  logic [1:0]        o_memSize;
  logic [14:0]       o_memAdr;
  logic [2:0]        o_memSubAdr;
  logic [15:0]       o_memMask;
  logic [PW-1:0]     o_owner;

  always #5 clk = ~clk;

  psx_mem_arbiter #(.NCLIENT(NC), .PTR_W(PW)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_cmd(cmd_v), .i_write(wr_v), .i_size(size_v),
    .i_adr(adr_v), .i_subAdr(sub_v), .i_mask(mask_v), .i_data(data_v),
    .o_busy(o_busy), .o_dataValid(o_dataValid), .o_data(o_data),
    .o_memCmd(o_memCmd), .o_memWrite(o_memWrite), .o_memSize(o_memSize),
    .o_memAdr(o_memAdr), .o_memSubAdr(o_memSubAdr), .o_memMask(o_memMask),
    .o_memData(o_memData), .i_memBusy(mem_busy), .i_memDataValid(mem_dv),
    .i_memData(mem_rdata), .o_owner(o_owner)
  );

  // A client must never pulse a command while its slot is busy
  always @(posedge clk) begin
    if (!rst) begin
      a_no_cmd_while_busy: assert ((cmd_v & o_busy) == '0)
        else $error("client command while busy: cmd=%b busy=%b", cmd_v, o_busy);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic         wr;
    logic [1:0]   size;
    logic [14:0]  adr;
    logic [2:0]   sub;
    logic [15:0]  mask;
    logic [255:0] data;
  } req_t;

  // Stimulus for the current cycle
  req_t          d_req [NC];
  logic [NC-1:0] d_cmd   = '0;
  bit            d_rst   = 1'b0;
  bit            d_stray = 1'b0;

  // Bridge model state
  bit           br_on = 0, br_wr = 0, br_fixed = 0;
  int           br_t = 0, br_len = 1, br_len_force = 0;
  logic [255:0] br_fill = '0;

  // Reference model: pending set, one in-flight transaction, last grant
  req_t          m_req [NC];
  logic [NC-1:0] m_pend = '0;
  bit            m_act = 0, m_wr = 0, m_known = 0;
  int            m_own = 0, m_issue = 0, m_last = NC-1;
  logic [255:0]  m_data = '0;
  logic [NC-1:0] e_dv = '0;
  bit            e_cmd = 0;
  int            cyc = 0;
  int            dut_grants[$];

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input int k, input logic wr, input logic [1:0] sz, input logic [14:0] adr,
                         input logic [2:0] sub, input logic [15:0] mask, input logic [255:0] data);
    d_cmd[k]      = 1'b1;
    d_req[k].wr   = wr;
    d_req[k].size = sz;
    d_req[k].adr  = adr;
    d_req[k].sub  = sub;
    d_req[k].mask = mask;
    d_req[k].data = data;
  endtask

  // One clock: bridge reacts, ports driven, reference advanced, outputs checked
  task automatic step();
    logic busy, dv;
    logic [255:0] rd;
    logic [NC-1:0] pend_now;
    int w;
    busy = 1'b0;
    dv   = 1'b0;
    rd   = br_fixed ? br_fill : rand256();
    if (o_memCmd === 1'b1) begin
      br_on  = 1;
      br_t   = 0;
      br_wr  = o_memWrite;
      br_len = (br_len_force != 0) ? br_len_force : $urandom_range(1, 5);
    end else if (br_on) begin
      br_t++;
    end
    if (br_on) begin
      busy = (br_t >= 2) && (br_t < 2 + br_len);
      if (br_t == 2 + br_len) begin
        dv    = !br_wr;
        br_on = 0;
      end
    end else if (d_stray) begin
      dv = 1'b1;
    end

    rst       = d_rst;
    cmd_v     = d_cmd;
    mem_busy  = busy;
    mem_dv    = dv;
    mem_rdata = rd;
    for (int k = 0; k < NC; k++) begin
      wr_v[k]               = d_req[k].wr;
      size_v[2*k +: 2]      = d_req[k].size;
      adr_v[15*k +: 15]     = d_req[k].adr;
      sub_v[3*k +: 3]       = d_req[k].sub;
      mask_v[16*k +: 16]    = d_req[k].mask;
      data_v[256*k +: 256]  = d_req[k].data;
    end

    e_dv  = '0;
    e_cmd = 0;
    if (d_rst) begin
      m_pend  = '0;
      m_act   = 0;
      m_own   = 0;
      m_last  = NC-1;
      m_known = 0;
    end else begin
      pend_now = m_pend;
      if (m_act && cyc > m_issue) begin
        if (!m_wr && dv) begin
          m_pend[m_own] = 1'b0;
          m_act         = 0;
          e_dv[m_own]   = 1'b1;
          m_data        = rd;
          m_known       = 1;
        end else if (m_wr && cyc >= m_issue + 2 && !busy) begin
          m_pend[m_own] = 1'b0;
          m_act         = 0;
        end
      end else if (!m_act && !busy && pend_now != '0) begin
        w = -1;
`ifdef PSX_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NC; i++) if (w < 0 && pend_now[i]) w = i;
`else
        for (int i = 1; i <= NC; i++) if (w < 0 && pend_now[(m_last + i) % NC]) w = (m_last + i) % NC;
`endif
        m_act   = 1;
        m_own   = w;
        m_wr    = m_req[w].wr;
        m_issue = cyc + 1;
        m_last  = w;
        e_cmd   = 1;
      end
      for (int k = 0; k < NC; k++) begin
        if (d_cmd[k] && !pend_now[k]) begin
          m_pend[k] = 1'b1;
          m_req[k]  = d_req[k];
        end
      end
    end
    d_cmd   = '0;
    d_rst   = 1'b0;
    d_stray = 1'b0;

    @(posedge clk);
    cyc++;
    @(negedge clk);

    if (o_memCmd === 1'b1) dut_grants.push_back(int'(o_owner));
    check_val("busy", o_busy, m_pend);
    check_val("dataValid", o_dataValid, e_dv);
    check_val("memCmd", o_memCmd, e_cmd);
    check_val("owner", o_owner, m_own);
    if (m_known) check_val("rdata", o_data, m_data);
    if (e_cmd) begin
      check_val("memWrite", o_memWrite, m_req[m_own].wr);
      check_val("memSize", o_memSize, m_req[m_own].size);
      check_val("memAdr", o_memAdr, m_req[m_own].adr);
      check_val("memSubAdr", o_memSubAdr, m_req[m_own].sub);
      check_val("memMask", o_memMask, m_req[m_own].mask);
      check_val("memData", o_memData, m_req[m_own].data);
    end else if (m_act && m_wr) begin
      check_val("wr_mask_hold", o_memMask, m_req[m_own].mask);
      check_val("wr_data_hold", o_memData, m_req[m_own].data);
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    bit timed_out;
    n = 0;
    while ((m_pend != '0 || m_act || br_on) && n < budget) begin
      step();
      n++;
    end
    timed_out = (m_pend != '0 || m_act || br_on);
    check_val("idle_timeout", timed_out, 1'b0);
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    step();
    d_rst = 1'b1;
    step();
  endtask

  initial begin
    for (int k = 0; k < NC; k++) begin
      d_req[k] = '{wr: 1'b0, size: 2'd0, adr: '0, sub: '0, mask: '0, data: '0};
      m_req[k] = d_req[k];
    end

    // Reset state
    do_reset();
    check_val("rst_memWrite", o_memWrite, 1'b0);
    check_val("rst_memSize", o_memSize, 2'd0);
    check_val("rst_memAdr", o_memAdr, 15'd0);
    check_val("rst_memSubAdr", o_memSubAdr, 3'd0);
    check_val("rst_memMask", o_memMask, 16'd0);
    check_val("rst_memData", o_memData, 256'd0);

    // Single read by client 1, fixed A5 return pattern
    br_fixed = 1;
    br_fill  = {32{8'hA5}};
    br_len_force = 4;
    set_req(1, 1'b0, 2'd1, 15'h1234, 3'd0, 16'h0000, rand256());
    step();
    run_idle(40);
    check_val("single_rdata", o_data, {32{8'hA5}});
    br_fixed = 0;
    br_len_force = 0;

    // Three simultaneous reads from reset: grants 0,1,2
    do_reset();
    dut_grants.delete();
    for (int k = 0; k < NC; k++) set_req(k, 1'b0, 2'd1, 15'(k * 16 + 3), 3'(k), 16'hFFFF, rand256());
    step();
    run_idle(80);
    check_val("all3_count", dut_grants.size(), 3);
    for (int i = 0; i < 3; i++)
      check_val("all3_order", (dut_grants.size() > i) ? dut_grants[i] : -1, i);

    // Client 0 re-requests on every completion while client 2 waits
    do_reset();
    dut_grants.delete();
    set_req(0, 1'b0, 2'd0, 15'h0100, 3'd0, 16'h0, rand256());
    set_req(2, 1'b0, 2'd0, 15'h0200, 3'd0, 16'h0, rand256());
    step();
    for (int n = 0, re = 0; n < 120 && (re < 3 || m_pend != '0 || m_act || br_on); n++) begin
      if (re < 3 && !m_pend[0]) begin
        set_req(0, 1'b0, 2'd0, 15'(16'h0101 + re), 3'd0, 16'h0, rand256());
        re++;
      end
      step();
    end
    run_idle(40);
`ifndef PSX_ARB_FIXED_PRIO_EN
    check_val("rr_second_grant", (dut_grants.size() > 1) ? dut_grants[1] : -1, 2);
`endif

    // 4-byte write by client 2
    set_req(2, 1'b1, 2'd2, 15'h0055, 3'b001, 16'h0003, rand256());
    step();
    run_idle(40);

    // Reset while a read waits on a busy bridge, then a request right after
    br_len_force = 5;
    set_req(1, 1'b0, 2'd1, 15'h0777, 3'd0, 16'h0, rand256());
    step();
    for (int n = 0; n < 20 && !(br_on && mem_busy); n++) step();
    check_val("rst_mid_reached", br_on && mem_busy, 1'b1);
    d_rst = 1'b1;
    step();
    set_req(0, 1'b0, 2'd0, 15'h0042, 3'd0, 16'h0, rand256());
    step();
    run_idle(60);
    br_len_force = 0;

    // Stray bridge valid while idle
    for (int n = 0; n < 4; n++) begin
      d_stray = 1'b1;
      step();
    end

    // Randomised traffic with stray valids and occasional mid-read resets
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NC; k++)
        if (!m_pend[k] && $urandom_range(0, 3) == 0)
          set_req(k, 1'($urandom), 2'($urandom_range(0, 2)), 15'($urandom), 3'($urandom),
                  16'($urandom), rand256());
      if ($urandom_range(0, 15) == 0) d_stray = 1'b1;
      if (br_on && !br_wr && mem_busy && $urandom_range(0, 63) == 0) d_rst = 1'b1;
      step();
    end
    run_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psx_mem_arbiter.md
Name: psx_mem_arbiter

Overview:
- Shares the single PSX-side DDR bridge port between NCLIENT requesters (client 0 = GPU, 1 = MDEC, 2 = CPU/DMA).
- Each client sees the bridge's native client protocol: a command pulse while not busy, then busy until done, with a read-data valid pulse.
- The block buffers one pending command per client, arbitrates round-robin and issues exactly one command at a time to the bridge.
- It routes the returned read data and valid pulse back to the owning client only.

Parameters:
- NCLIENT, 3, number of requesters (2..4).
- PTR_W, 2, width of the round-robin pointer and owner index (must satisfy 2^PTR_W >= NCLIENT).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_cmd  in  NCLIENT  per-client command pulse.
- i_write  in  NCLIENT  per-client 1=write, 0=read.
- i_size  in  2*NCLIENT  per-client size: 0=8B, 1=32B, 2=4B.
- i_adr  in  15*NCLIENT  per-client 32-byte block address.
- i_subAdr  in  3*NCLIENT  per-client 4-byte sub address.
- i_mask  in  16*NCLIENT  per-client 16-bit write mask.
- i_data  in  256*NCLIENT  per-client write data.
- o_busy  out  NCLIENT  per-client busy.
- o_dataValid  out  NCLIENT  per-client read-data valid.
- o_data  out  256  read data, shared by all clients.
- o_memCmd  out  1  command to bridge.
- o_memWrite  out  1  1=write, 0=read.
- o_memSize  out  2  command size.
- o_memAdr  out  15  block address.
- o_memSubAdr  out  3  sub address.
- o_memMask  out  16  write mask.
- o_memData  out  256  write data.
- i_memBusy  in  1  bridge busy.
- i_memDataValid  in  1  bridge read-data valid.
- i_memData  in  256  bridge read data.
- o_owner  out  PTR_W  index of the client currently served (debug).

Behaviour:
- Reset: all slots empty; state IDLE; o_busy=0; o_dataValid=0; o_memCmd=0; rr pointer=NCLIENT-1; o_owner=0. All o_mem* fields are registered and reset to 0.
- Slot capture: on i_cmd[k]=1 with slot k empty, latch write/size/adr/subAdr/mask/data into slot k and set it valid.
  - o_busy[k] = slot_valid[k], so busy is seen from the cycle after capture.
  - i_cmd[k] while o_busy[k]=1 is a client protocol violation and is ignored. The bench flags it with an assertion.
- Simultaneous capture: any number of clients may capture in the same cycle.
- State IDLE:
  - Stays in IDLE while i_memBusy=1. This covers a bridge still draining after a reset.
  - Otherwise, if any slot is valid, select the winner by round-robin starting at pointer+1 modulo NCLIENT.
  - On selection, register the winner's fields onto o_mem*, set owner and pointer to the winner, and go to ISSUE.
  - A slot captured in the same cycle is not eligible until the next cycle.
- State ISSUE:
  - o_memCmd=1 for exactly one cycle, with fields stable.
  - Next state is WAIT_W if the command is a write, WAIT_R if it is a read.
- State WAIT_W:
  - The first cycle after ISSUE is ignored because the bridge raises busy one cycle late.
  - From the second cycle on, i_memBusy=0 means done: clear slot[owner] and return to IDLE.
- State WAIT_R:
  - On i_memDataValid=1: register i_memData to o_data and pulse o_dataValid[owner] for 1 cycle.
  - Clear slot[owner] in the same edge and return to IDLE.
- Latency:
  - Command pulse to o_memCmd is 2 cycles when idle and the bridge is free (capture, then IDLE select, then ISSUE).
  - Bridge valid to client valid is 1 cycle.
  - After completion, the next grant's ISSUE is 2 cycles later.
- Stray data: i_memDataValid outside WAIT_R produces no client valid.
- o_data holds its last value between reads.
- Mid-operation reset: slots are cleared and the FSM returns to IDLE. No client valid is produced for an in-flight read.
- Fields held in o_mem* are don't-care outside ISSUE, except that o_memData and o_memMask must stay stable through WAIT_W, because the bridge samples them at command time.

Optional Feature:
- Macro PSX_ARB_FIXED_PRIO_EN.
- Defined: selection is fixed priority, lowest index wins (GPU first), and the rr pointer is unused.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Test Plan:
- Single read, client 1, adr=0x1234, size=1: o_memCmd pulses 2 cycles after i_cmd[1]. The bridge model returns data=0xA5.. after 6 cycles, giving o_dataValid=3'b010 one cycle later with o_data=0xA5... o_busy[1] drops on the same edge.
- All three clients pulse i_cmd in the same cycle (reads): grants in order 0,1,2, each valid pulse goes only to its owner, and no two o_memCmd pulses overlap a busy bridge.
- Client 0 re-requests immediately after each completion while client 2 is pending: client 2 is granted second (round-robin fairness). With PSX_ARB_FIXED_PRIO_EN, client 0 is granted repeatedly until idle.
- Write 4B, client 2, subAdr=3'b001, mask=16'h0003: o_memWrite=1, o_memSubAdr=1, o_memMask=0x0003. The slot clears when the bridge busy falls, and no o_dataValid is produced.
- i_rst asserted during WAIT_R with bridge busy=1: o_busy=0 next cycle, and the late i_memDataValid produces no client valid. A new request is not issued until i_memBusy=0.
- i_memDataValid injected while IDLE: all o_dataValid stay 0 and o_data is unchanged.
